prbs_checker: RTL and testbench

Receive-side PRBS22 checker for modem loopback and BER testing. It takes the demodulated 2-bit I/Q symbol stream produced from the modem's PRBS22 stimulus and self-synchronises to the sequence. Once locked, it flywheels a local predictor and counts bit errors and checked bits, and it reports lock, per-symbol error pulses and sequence rollover. It sits after the slicer, in the sym_clk_ena domain of the single system clock.

---
 rtl/dspmodem_pkg.sv | 17 +
 rtl/prbs_checker_if.sv | 24 ++
 rtl/prbs22_predict.sv | 17 +
 rtl/prbs_checker.sv | 155 +++++++++++++++
 tb/tb_prbs_checker.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dspmodem_pkg.sv
// Shared PRBS22 constants and checker state type for the modem datapath.
package dspmodem_pkg;

    localparam int PRBS_LEN   = 22;
    localparam int PRBS_TAP_A = 21;
    localparam int PRBS_TAP_B = 22;
    localparam logic [PRBS_LEN-1:0] PRBS_ROLL = 22'h3FFFFF;
    // Two bits enter the history per symbol, so a full history takes half its length.
    localparam int FILL_SYMS  = PRBS_LEN / 2;

    typedef enum logic [1:0] {
        FILL,
        SEARCH,
        LOCKED
    } chk_state_e;

endpackage

// File: rtl/prbs_checker_if.sv
// Symbol-rate bus between the slicer and the PRBS checker, plus the checker's status outputs.
interface prbs_checker_if #(
    parameter int CNT_W = 32
);
    logic             sym_clk_ena;
    logic [1:0]       rx_i;
    logic [1:0]       rx_q;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic             rollover;

    modport master (
        output sym_clk_ena, rx_i, rx_q, clear_counts,
        input  locked, err_pulse, err_count, bit_count, rollover
    );

    modport slave (
        input  sym_clk_ena, rx_i, rx_q, clear_counts,
        output locked, err_pulse, err_count, bit_count, rollover
    );
endinterface

// File: rtl/prbs22_predict.sv
// Combinational PRBS22 two-bit predictor; hist_i[k] holds sequence bit b[n-1-k].
module prbs22_predict
    import dspmodem_pkg::*;
(
    input  logic [PRBS_LEN-1:0] hist_i,
    output logic [1:0]          pred_o,
    output logic [PRBS_LEN-1:0] next_o
);
    logic p0;
    logic p1;

    assign p0     = hist_i[PRBS_TAP_A-1] ^ hist_i[PRBS_TAP_B-1];
    assign p1     = hist_i[PRBS_TAP_A-2] ^ hist_i[PRBS_TAP_B-2];
    assign pred_o = {p1, p0};
    // Newest bit lands in bit 0, so p1 (the later bit) goes last.
    assign next_o = {hist_i[PRBS_LEN-3:0], p0, p1};
endmodule

// File: rtl/prbs_checker.sv
// PRBS22 receive checker: self-synchronises on rx_i, then flywheels and counts I/Q bit errors.
module prbs_checker
    import dspmodem_pkg::*;
#(
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           reset,
    prbs_checker_if.slave bus
);
    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W  = $clog2(LOSS_WINDOW);
    localparam int WERR_W = $clog2(4 * LOSS_WINDOW + 1);
    localparam int FILL_W = $clog2(FILL_SYMS + 1);

    chk_state_e          state_q, state_d;
    logic [PRBS_LEN-1:0] hist_q, hist_d, hist_fly;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]   win_errs_q, win_errs_d, win_total;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [1:0]          q_prev_q, pred;
    logic                q_chk_q, q_chk_d;
    logic                locked_q, err_pulse_q, err_pulse_d, rollover_q;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
    logic [2:0]          i_errs, q_errs, sym_errs;

    prbs22_predict u_predict (
        .hist_i (hist_q),
        .pred_o (pred),
        .next_o (hist_fly)
    );

    function automatic logic [2:0] popcount2(input logic [1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-2){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // rx_q of the previous symbol carries the bits this symbol's rx_i should hold.
    assign i_errs    = popcount2(bus.rx_i ^ pred);
    assign q_errs    = q_chk_q ? popcount2(q_prev_q ^ pred) : 3'd0;
    assign sym_errs  = i_errs + q_errs;
    assign win_total = win_errs_q + WERR_W'(sym_errs);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        hist_d      = hist_q;
        good_d      = good_q;
        win_cnt_d   = win_cnt_q;
        win_errs_d  = win_errs_q;
        fill_d      = fill_q;
        q_chk_d     = q_chk_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        if (bus.sym_clk_ena) begin
            unique case (state_q)
                FILL: begin
                    hist_d = {hist_q[PRBS_LEN-3:0], bus.rx_i[0], bus.rx_i[1]};
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_W'(FILL_SYMS - 1)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                    end
                end
                SEARCH: begin
                    hist_d = {hist_q[PRBS_LEN-3:0], bus.rx_i[0], bus.rx_i[1]};
                    // An all-zero history predicts zeros forever; never count it as sync.
                    if (bus.rx_i == pred && hist_q != '0) good_d = good_q + 1'b1;
                    else                                   good_d = '0;
                    if (good_d == GOOD_W'(LOCK_THRESH)) begin
                        state_d    = LOCKED;
                        good_d     = '0;
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                        q_chk_d    = 1'b0;
                    end
                end
                LOCKED: begin
                    hist_d      = hist_fly;
                    q_chk_d     = 1'b1;
                    err_pulse_d = (sym_errs != 3'd0);
                    err_cnt_d   = sat_add(err_cnt_q, sym_errs);
                    bit_cnt_d   = sat_add(bit_cnt_q, q_chk_q ? 3'd4 : 3'd2);
                    if (win_cnt_q == WIN_W'(LOSS_WINDOW - 1)) begin
                        win_cnt_d  = '0;
                        win_errs_d = '0;
                        if (win_total >= WERR_W'(LOSS_THRESH)) begin
                            state_d = SEARCH;
                            q_chk_d = 1'b0;
                        end
                    end else begin
                        win_cnt_d  = win_cnt_q + 1'b1;
                        win_errs_d = win_total;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        if (bus.clear_counts) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            hist_q      <= '0;
            good_q      <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            fill_q      <= '0;
            q_prev_q    <= '0;
            q_chk_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            rollover_q  <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            hist_q      <= hist_d;
            good_q      <= good_d;
            win_cnt_q   <= win_cnt_d;
            win_errs_q  <= win_errs_d;
            fill_q      <= fill_d;
            q_chk_q     <= q_chk_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
            rollover_q  <= bus.sym_clk_ena && (hist_d == PRBS_ROLL);
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            if (bus.sym_clk_ena) q_prev_q <= bus.rx_q;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.rollover  = rollover_q;
    assign bus.err_count = err_cnt_q;
    assign bus.bit_count = bit_cnt_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: a bit-queue model of the sequence and checker is compared every cycle.
module tb_prbs_checker;
    localparam int LOCK_THRESH = 16;
    localparam int LOSS_WINDOW = 64;
    localparam int LOSS_THRESH = 8;
    localparam int M_FILL = 0, M_SEARCH = 1, M_LOCKED = 2;

    logic clk = 1'b0;
    logic reset;

    prbs_checker_if #(.CNT_W(32)) ifa ();
    prbs_checker_if #(.CNT_W(4))  ifs ();

    prbs_checker #(.LOCK_THRESH(LOCK_THRESH), .LOSS_WINDOW(LOSS_WINDOW),
                   .LOSS_THRESH(LOSS_THRESH), .CNT_W(32)) dut (
        .clk (clk), .reset (reset), .bus (ifa));

    prbs_checker #(.LOCK_THRESH(LOCK_THRESH), .LOSS_WINDOW(LOSS_WINDOW),
                   .LOSS_THRESH(LOSS_THRESH), .CNT_W(4)) dut_s (
        .clk (clk), .reset (reset), .bus (ifs));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transmitted sequence, seeded with 22 ones.
    bit gseq[$];
    int gk;

    function automatic bit gbit(input int n);
        while (gseq.size() <= n) begin
            int m = gseq.size();
            gseq.push_back((m < 22) ? 1'b1 : (gseq[m-21] ^ gseq[m-22]));
        end
        return gseq[n];
    endfunction

    // Checker model: mh holds the bits the checker has accepted, oldest first.
    bit         mh[$];
    int         m_mode, m_fill, m_good, m_lsyms, m_wsyms, m_wsum;
    logic [1:0] m_qprev;
    longint     m_errs, m_bits;
    bit         e_locked, e_pulse, e_roll, fresh;

    function automatic void model_reset();
        mh.delete();
        for (int i = 0; i < 22; i++) mh.push_back(1'b0);
        m_mode = M_FILL; m_fill = 0; m_good = 0; m_lsyms = 0; m_wsyms = 0; m_wsum = 0;
        m_qprev = 2'b00; m_errs = 0; m_bits = 0;
        e_locked = 0; e_pulse = 0; e_roll = 0; fresh = 0;
    endfunction

    function automatic void model_symbol(input logic [1:0] ri, input logic [1:0] rq, input bit clr);
        int L;
        bit p0, p1, all0, all1;
        int errs;
        L  = mh.size();
        p0 = mh[L-21] ^ mh[L-22];
        p1 = mh[L-20] ^ mh[L-21];
        all0 = 1;
        for (int i = L - 22; i < L; i++) if (mh[i]) all0 = 0;
        errs = 0;
        e_pulse = 0;
        case (m_mode)
            M_FILL: begin
                mh.push_back(ri[0]); mh.push_back(ri[1]);
                m_fill++;
                if (m_fill == 11) m_mode = M_SEARCH;
            end
            M_SEARCH: begin
                if (ri[0] == p0 && ri[1] == p1 && !all0) m_good++;
                else m_good = 0;
                mh.push_back(ri[0]); mh.push_back(ri[1]);
                if (m_good == LOCK_THRESH) begin
                    m_mode = M_LOCKED; m_good = 0; m_lsyms = 0; m_wsyms = 0; m_wsum = 0;
                end
            end
            default: begin
                errs = int'(ri[0] != p0) + int'(ri[1] != p1);
                if (m_lsyms > 0) errs += int'(m_qprev[0] != p0) + int'(m_qprev[1] != p1);
                mh.push_back(p0); mh.push_back(p1);
                m_errs += errs;
                m_bits += (m_lsyms > 0) ? 4 : 2;
                m_lsyms++;
                e_pulse = (errs > 0);
                m_wsum += errs;
                m_wsyms++;
                if (m_wsyms == LOSS_WINDOW) begin
                    if (m_wsum >= LOSS_THRESH) begin
                        m_mode = M_SEARCH; m_good = 0;
                    end
                    m_wsyms = 0; m_wsum = 0;
                end
            end
        endcase
        if (clr) begin m_errs = 0; m_bits = 0; end
        m_qprev = rq;
        while (mh.size() > 22) void'(mh.pop_front());
        all1 = 1;
        foreach (mh[i]) if (!mh[i]) all1 = 0;
        e_roll   = all1;
        e_locked = (m_mode == M_LOCKED);
        fresh    = 1;
    endfunction

    function automatic logic [63:0] sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Per-cycle comparison; pulses are expected only on the cycle right after a strobe edge.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked",      ifa.locked,    e_locked);
            check("err_pulse",   ifa.err_pulse, fresh ? e_pulse : 1'b0);
            check("rollover",    ifa.rollover,  fresh ? e_roll  : 1'b0);
            check("err_count",   ifa.err_count, sat(m_errs, 32));
            check("bit_count",   ifa.bit_count, sat(m_bits, 32));
            check("w4_locked",   ifs.locked,    e_locked);
            check("w4_err_count", ifs.err_count, sat(m_errs, 4));
            check("w4_bit_count", ifs.bit_count, sat(m_bits, 4));
            fresh = 0;
        end
    end

    int sym_no, lock_sym, first_roll, roll_cnt, pulse_cnt;

    task automatic drive(input bit ena, input logic [1:0] ri, input logic [1:0] rq, input bit clr);
        ifa.sym_clk_ena = ena; ifa.rx_i = ri; ifa.rx_q = rq; ifa.clear_counts = clr;
        ifs.sym_clk_ena = ena; ifs.rx_i = ri; ifs.rx_q = rq; ifs.clear_counts = clr;
    endtask

    task automatic sym(input logic [1:0] ri, input logic [1:0] rq, input bit clr);
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            drive(1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
        @(negedge clk);
        drive(1'b1, ri, rq, clr);
        @(posedge clk);
        model_symbol(ri, rq, clr);
        #1;
        drive(1'b0, ri, rq, 1'b0);
        sym_no++;
        if (ifa.err_pulse) pulse_cnt++;
        if (ifa.rollover) begin
            roll_cnt++;
            if (first_roll < 0) first_roll = sym_no;
        end
        if (ifa.locked && lock_sym < 0) lock_sym = sym_no;
    endtask

    task automatic send(input logic [1:0] fi, input logic [1:0] fq, input bit clr);
        logic [1:0] ri, rq;
        ri = {gbit(2*gk + 1), gbit(2*gk)} ^ fi;
        rq = {gbit(2*gk + 3), gbit(2*gk + 2)} ^ fq;
        gk++;
        sym(ri, rq, clr);
    endtask

    task automatic reset_assert();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic reset_release();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        gk = 0; sym_no = 0; lock_sym = -1; first_roll = -1; roll_cnt = 0; pulse_cnt = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop_sym, relock_sym, burst_sym;
        bit ever_locked;
        logic [1:0] fi, fq, one_bit;

        reset = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        model_reset();
        cmp_en = 1;
        reset_release();
        check("reset_locked", ifa.locked, 1'b0);
        check("reset_err_count", ifa.err_count, 0);
        check("reset_bit_count", ifa.bit_count, 0);

        // Clean stream from the all-ones seed.
        for (int i = 0; i < 40 && lock_sym < 0; i++) send(2'b00, 2'b00, 1'b0);
        check("lock_symbol", lock_sym, 27);
        check("first_rollover_symbol", first_roll, 11);
        repeat (1000) send(2'b00, 2'b00, 1'b0);
        check("clean_err_count", ifa.err_count, 0);
        check("clean_bit_count", ifa.bit_count, 3998);
        check("rollover_count", roll_cnt, 1);

        // One flipped I bit: counted once, no multiplication.
        pulse_cnt = 0;
        one_bit = 2'b01 << $urandom_range(0, 1);
        send(one_bit, 2'b00, 1'b0);
        repeat (40) send(2'b00, 2'b00, 1'b0);
        check("single_err_count", ifa.err_count, 1);
        check("single_pulses", pulse_cnt, 1);
        check("single_locked", ifa.locked, 1'b1);

        // 8-bit burst placed early in a window.
        for (int i = 0; i < 200 && !(m_mode == M_LOCKED && m_wsyms == 5); i++) send(2'b00, 2'b00, 1'b0);
        burst_sym = sym_no + 1;
        repeat (4) send(2'b11, 2'b00, 1'b0);
        drop_sym = -1;
        for (int i = 0; i < 100 && drop_sym < 0; i++) begin
            send(2'b00, 2'b00, 1'b0);
            if (!ifa.locked) drop_sym = sym_no;
        end
        check("loss_latency", drop_sym - burst_sym, 58);
        relock_sym = -1;
        for (int i = 0; i < 40 && relock_sym < 0; i++) begin
            send(2'b00, 2'b00, 1'b0);
            if (ifa.locked) relock_sym = sym_no;
        end
        check("relock_latency", relock_sym - drop_sym, 16);

        // Saturation of the 4-bit counters and clear priority.
        send(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(2'b01, 2'b00, 1'b0);
            repeat (9) send(2'b00, 2'b00, 1'b0);
        end
        check("w4_err_saturated", ifs.err_count, 15);
        check("w32_err_count", ifa.err_count, 16);
        check("sat_locked", ifa.locked, 1'b1);
        send(2'b10, 2'b00, 1'b1);
        check("clear_prio_w4_err", ifs.err_count, 0);
        check("clear_prio_err", ifa.err_count, 0);
        check("clear_prio_bits", ifa.bit_count, 0);

        // Random channel errors on I and Q with occasional clears.
        for (int i = 0; i < 600; i++) begin
            fi = ($urandom_range(0, 99) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
            fq = ($urandom_range(0, 99) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
            send(fi, fq, $urandom_range(0, 99) == 0);
        end

        // All-zero input must never lock.
        reset_assert();
        reset_release();
        ever_locked = 0;
        for (int i = 0; i < 100; i++) begin
            sym(2'b00, 2'b00, 1'b0);
            if (ifa.locked) ever_locked = 1;
        end
        check("zero_never_locked", ever_locked, 1'b0);

        // Asynchronous reset mid-lock.
        reset_assert();
        reset_release();
        for (int i = 0; i < 40 && lock_sym < 0; i++) send(2'b00, 2'b00, 1'b0);
        check("lock_after_reset", lock_sym, 27);
        repeat (10) send(2'b00, 2'b00, 1'b0);
        reset_assert();
        #1;
        check("async_reset_locked", ifa.locked, 1'b0);
        check("async_reset_bits", ifa.bit_count, 0);
        reset_release();
        for (int i = 0; i < 40 && lock_sym < 0; i++) send(2'b00, 2'b00, 1'b0);
        check("fill_restart_lock", lock_sym, 27);

        @(negedge clk);
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
